// File: rtl/dtw_dispatch_arbiter.sv
// DTW dispatch arbiter: streams queries from one source FIFO to idle cores.
// It also collects 3-word results round-robin. Optional stats: DTW_DISPATCH_STATS_EN.
module dtw_dispatch_arbiter #(
  parameter int N_CORES    = 4,
  parameter int SQG_SIZE   = 250,
  parameter int axi_dwidth = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  output logic                          busy,
  output logic                          src_fifo_rden,
  input  logic                          src_fifo_empty,
  input  logic [axi_dwidth-1:0]         src_fifo_data,
  output logic [N_CORES-1:0]            core_start,
  input  logic [N_CORES-1:0]            core_running,
  output logic [N_CORES-1:0]            core_src_empty,
  input  logic [N_CORES-1:0]            core_src_rden,
  output logic [axi_dwidth-1:0]         core_src_data,
  input  logic [N_CORES-1:0]            core_sink_wren,
  input  logic [N_CORES*axi_dwidth-1:0] core_sink_data,
  output logic [N_CORES-1:0]            core_sink_full,
  output logic                          sink_fifo_wren,
  input  logic                          sink_fifo_full,
  output logic [axi_dwidth-1:0]         sink_fifo_data
`ifdef DTW_DISPATCH_STATS_EN
  ,
  output logic [31:0]                   stat_dispatched,
  output logic [31:0]                   stat_returned
`endif
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CW = $clog2(SQG_SIZE + 2);

  typedef enum logic [1:0] {
    D_IDLE, D_SELECT, D_START, D_STREAM
  } dstate_t;

  dstate_t         state, state_nx;
  logic [IW-1:0]   dp, sel, pick_d;
  logic            found_d;
  logic [CW-1:0]   wcnt;
  logic            xfer, last_word;

  logic            gv, found_r, acc;
  logic [IW-1:0]   g, rp, pick_r;
  logic [1:0]      rcnt;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    if (int'(v) == N_CORES - 1) return '0;
    return v + IW'(1);
  endfunction

  assign core_src_data = src_fifo_data;
  assign xfer      = (state == D_STREAM) && core_src_rden[sel] && !src_fifo_empty;
  assign last_word = xfer && (wcnt == CW'(SQG_SIZE));
  assign busy      = !rst && ((state != D_IDLE) || (|core_running));

  // Round-robin search for the first idle core starting at dp
  always_comb begin
    found_d = 1'b0;
    pick_d  = dp;
    for (int i = 0; i < N_CORES; i++) begin
      int k;
      k = int'(dp) + i;
      if (k >= N_CORES) k = k - N_CORES;
      if (!found_d && !core_running[IW'(k)]) begin
        found_d = 1'b1;
        pick_d  = IW'(k);
      end
    end
  end

  // Dispatch state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= D_IDLE;
    else     state <= state_nx;
  end

  // Dispatch next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      D_IDLE:   if (enable && !src_fifo_empty) state_nx = D_SELECT;
      D_SELECT: if (found_d) state_nx = D_START;
      D_START:  state_nx = D_STREAM;
      D_STREAM: if (last_word) state_nx = D_IDLE;
      default:  state_nx = D_IDLE;
    endcase
  end

  // Dispatch outputs: only the selected core sees the source while streaming
  always_comb begin
    core_start     = '0;
    core_src_empty = '1;
    src_fifo_rden  = 1'b0;
    if (state == D_START) core_start[sel] = 1'b1;
    if (state == D_STREAM) begin
      core_src_empty[sel] = src_fifo_empty;
      src_fifo_rden       = core_src_rden[sel];
    end
  end

  // Dispatch datapath: selected core, word counter, dispatch pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel  <= '0;
      dp   <= '0;
      wcnt <= '0;
    end else begin
      if (state == D_SELECT && found_d) sel <= pick_d;
      if (xfer) begin
        if (last_word) begin
          wcnt <= '0;
          dp   <= inc_mod(sel);
        end else begin
          wcnt <= wcnt + CW'(1);
        end
      end
    end
  end

  // Round-robin search for a requesting core starting at rp
  always_comb begin
    found_r = 1'b0;
    pick_r  = rp;
    for (int i = 0; i < N_CORES; i++) begin
      int k;
      k = int'(rp) + i;
      if (k >= N_CORES) k = k - N_CORES;
      if (!found_r && core_sink_wren[IW'(k)]) begin
        found_r = 1'b1;
        pick_r  = IW'(k);
      end
    end
  end

  assign acc = gv && core_sink_wren[g] && !sink_fifo_full;

  // Result grant: locks on one core for three accepted words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gv   <= 1'b0;
      g    <= '0;
      rp   <= '0;
      rcnt <= '0;
    end else if (!gv) begin
      if (found_r) begin
        gv <= 1'b1;
        g  <= pick_r;
      end
    end else if (acc) begin
      if (rcnt == 2'd2) begin
        gv   <= 1'b0;
        rcnt <= '0;
        rp   <= inc_mod(g);
      end else begin
        rcnt <= rcnt + 2'd1;
      end
    end
  end

  // Result outputs: non-granted cores see a full sink
  always_comb begin
    core_sink_full = '1;
    sink_fifo_wren = 1'b0;
    sink_fifo_data = '0;
    if (gv) begin
      core_sink_full[g] = sink_fifo_full;
      sink_fifo_wren    = core_sink_wren[g];
      sink_fifo_data    = core_sink_data[int'(g)*axi_dwidth +: axi_dwidth];
    end
  end

`ifdef DTW_DISPATCH_STATS_EN
  // Wrapping dispatch / result counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_dispatched <= '0;
      stat_returned   <= '0;
    end else begin
      if (state == D_START) stat_dispatched <= stat_dispatched + 32'd1;
      if (acc && rcnt == 2'd2) stat_returned <= stat_returned + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dtw_dispatch_arbiter.sv
// Bench for dtw_dispatch_arbiter: FIFO/core models with word scoreboards.
// Table-driven dispatch and collection vectors plus multi-cycle sequences.
module tb_dtw_dispatch_arbiter;
  localparam int N   = 4;
  localparam int SQG = 250;
  localparam int W   = 32;
  localparam int QW  = SQG + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           enable = 1'b0;
  logic           busy;
  logic           src_fifo_rden;
  logic           src_fifo_empty;
  logic [W-1:0]   src_fifo_data;
  logic [N-1:0]   core_start;
  logic [N-1:0]   core_running;
  logic [N-1:0]   core_src_empty;
  logic [N-1:0]   core_src_rden;
  logic [W-1:0]   core_src_data;
  logic [N-1:0]   core_sink_wren;
  logic [N*W-1:0] core_sink_data;
  logic [N-1:0]   core_sink_full;
  logic           sink_fifo_wren;
  logic           sink_fifo_full;
  logic [W-1:0]   sink_fifo_data;
`ifdef DTW_DISPATCH_STATS_EN
  logic [31:0]    stat_dispatched;
  logic [31:0]    stat_returned;
`endif

  always #5 clk = ~clk;

  dtw_dispatch_arbiter #(
    .N_CORES(N), .SQG_SIZE(SQG), .axi_dwidth(W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .busy(busy),
    .src_fifo_rden(src_fifo_rden), .src_fifo_empty(src_fifo_empty),
    .src_fifo_data(src_fifo_data), .core_start(core_start),
    .core_running(core_running), .core_src_empty(core_src_empty),
    .core_src_rden(core_src_rden), .core_src_data(core_src_data),
    .core_sink_wren(core_sink_wren), .core_sink_data(core_sink_data),
    .core_sink_full(core_sink_full), .sink_fifo_wren(sink_fifo_wren),
    .sink_fifo_full(sink_fifo_full), .sink_fifo_data(sink_fifo_data)
`ifdef DTW_DISPATCH_STATS_EN
    , .stat_dispatched(stat_dispatched), .stat_returned(stat_returned)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] src_q[$];
  logic [W-1:0] src_exp[$];
  logic [W-1:0] sink_exp[$];
  int           start_log[$];
  int           rx_cnt[N];
  logic [W-1:0] res_w[N][3];
  int           res_left[N];
  bit           pend_src;
  bit [N-1:0]   pend_core;
  bit           sink_full_m;
  bit           rden_seen;
  int           acc_cnt;
  int           qnum = 0;

  typedef struct {
    logic [N-1:0] running;
    int           core;
  } dvec_t;

  typedef struct {
    int first;
    int second;
  } cvec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected/timeout want in-bound event", nm);
  endtask

  function automatic int rx_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += rx_cnt[i];
    return s;
  endfunction

  function automatic int res_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += res_left[i];
    return s;
  endfunction

  function automatic int first_start(input int idx);
    if (start_log.size() > idx) return start_log[idx];
    return -1;
  endfunction

  // One clock of the source FIFO, core and sink FIFO models.
  task automatic tick();
    int got;
    bit sacc;
    @(negedge clk);
    if (pend_src && src_q.size() > 0) void'(src_q.pop_front());
    for (int i = 0; i < N; i++)
      if (pend_core[i] && res_left[i] > 0) res_left[i]--;
    pend_src  = 1'b0;
    pend_core = '0;
    src_fifo_empty = (src_q.size() == 0);
    src_fifo_data  = src_fifo_empty ? '0 : src_q[0];
    for (int i = 0; i < N; i++) begin
      core_src_rden[i]  = ($urandom_range(0, 3) != 0);
      core_sink_wren[i] = (res_left[i] > 0);
      core_sink_data[i*W +: W] =
        (res_left[i] > 0) ? res_w[i][3-res_left[i]] : '0;
    end
    sink_fifo_full = sink_full_m;
    #1;
    pend_src = src_fifo_rden && !src_fifo_empty;
    if (src_fifo_rden) rden_seen = 1'b1;
    got = 0;
    for (int i = 0; i < N; i++) begin
      if (core_src_rden[i] && !core_src_empty[i]) begin
        got++;
        rx_cnt[i]++;
        if (src_exp.size() == 0) fail_msg("src_extra_word");
        else chk("core_src_data", core_src_data, src_exp.pop_front());
      end
    end
    if (got != 0 || pend_src) chk("src_xfer_align", got, pend_src ? 1 : 0);
    if (core_start != '0) begin
      chk("start_onehot", $countones(core_start), 1);
      for (int i = 0; i < N; i++)
        if (core_start[i]) start_log.push_back(i);
    end
    for (int i = 0; i < N; i++)
      pend_core[i] = core_sink_wren[i] && !core_sink_full[i];
    sacc = sink_fifo_wren && !sink_fifo_full;
    if (sacc || pend_core != '0)
      chk("sink_core_align", $countones(pend_core), sacc ? 1 : 0);
    if (sacc) begin
      acc_cnt++;
      if (sink_exp.size() == 0) fail_msg("sink_extra_word");
      else chk("sink_data", sink_fifo_data, sink_exp.pop_front());
    end
  endtask

  task automatic queue_query();
    logic [W-1:0] w;
    qnum++;
    for (int k = 0; k < QW; k++) begin
      w = (k == 0) ? {8'hA5, 24'(qnum)} : $urandom;
      src_q.push_back(w);
      src_exp.push_back(w);
    end
  endtask

  task automatic load_res(input int c);
    for (int j = 0; j < 3; j++) begin
      res_w[c][j] = {4'(c), 4'(j), 24'($urandom)};
      sink_exp.push_back(res_w[c][j]);
    end
    res_left[c] = 3;
  endtask

  task automatic clear_logs();
    start_log.delete();
    for (int i = 0; i < N; i++) rx_cnt[i] = 0;
    acc_cnt = 0;
  endtask

  task automatic wait_src(input int budget, input string nm);
    int n = 0;
    while ((src_q.size() != 0 || pend_src) && n < budget) begin
      tick();
      n++;
    end
    if (src_q.size() != 0 || pend_src) fail_msg(nm);
    repeat (4) tick();
  endtask

  task automatic wait_sink(input int budget, input string nm);
    int n = 0;
    while ((sink_exp.size() != 0 || pend_core != '0 || res_total() != 0)
           && n < budget) begin
      tick();
      n++;
    end
    if (sink_exp.size() != 0 || res_total() != 0) fail_msg(nm);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_core_start"}, core_start, '0);
    chk({tag, "_src_rden"}, src_fifo_rden, 1'b0);
    chk({tag, "_sink_wren"}, sink_fifo_wren, 1'b0);
    chk({tag, "_sink_data"}, sink_fifo_data, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_src_empty"}, core_src_empty, {N{1'b1}});
    chk({tag, "_sink_full"}, core_sink_full, {N{1'b1}});
  endtask

  initial begin
    dvec_t dv[6];
    cvec_t cv[5];
    int n;

    dv[0] = '{running: 4'b0000, core: 3};
    dv[1] = '{running: 4'b0001, core: 1};
    dv[2] = '{running: 4'b0100, core: 3};
    dv[3] = '{running: 4'b0011, core: 2};
    dv[4] = '{running: 4'b1000, core: 0};
    dv[5] = '{running: 4'b1110, core: 0};

    cv[0] = '{first: 1, second: 3};
    cv[1] = '{first: 0, second: 2};
    cv[2] = '{first: 1, second: 2};
    cv[3] = '{first: 3, second: 0};
    cv[4] = '{first: 1, second: 0};

    core_running   = '0;
    core_src_rden  = '0;
    core_sink_wren = '0;
    core_sink_data = '0;
    src_fifo_empty = 1'b1;
    src_fifo_data  = '0;
    sink_fifo_full = 1'b0;
    sink_full_m    = 1'b0;
    pend_src       = 1'b0;
    pend_core      = '0;
    rden_seen      = 1'b0;
    for (int i = 0; i < N; i++) res_left[i] = 0;
    clear_logs();

    #2 rst = 1'b1;
    #1 check_reset_outs("rst_init");
    tick();
    tick();
    check_reset_outs("rst_hold");
    rst = 1'b0;
    enable = 1'b1;

    // three queries, all cores idle
    clear_logs();
    repeat (3) queue_query();
    wait_src(4000, "timeout_three_queries");
    chk("three_start_cnt", start_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("three_start_core", first_start(i), i);
      chk("three_rx_words", rx_cnt[i], QW);
    end
    chk("three_rx_core3", rx_cnt[3], 0);

    // round-robin selection against running masks
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      core_running = dv[v].running;
      queue_query();
      wait_src(1500, "timeout_dvec");
      chk("dvec_start_cnt", start_log.size(), 1);
      chk("dvec_start_core", first_start(0), dv[v].core);
      chk("dvec_rx_words", rx_cnt[dv[v].core], QW);
      core_running = '0;
    end

    // all cores running: hold in select, then core 2 frees up
    clear_logs();
    core_running = '1;
    queue_query();
    rden_seen = 1'b0;
    repeat (20) tick();
    chk("hold_no_start", start_log.size(), 0);
    chk("hold_no_read", src_q.size(), QW);
    chk("hold_no_rden", rden_seen, 1'b0);
    chk("hold_busy", busy, 1'b1);
    core_running = 4'b1011;
    wait_src(1500, "timeout_core2_free");
    chk("free_start_core", first_start(0), 2);
    chk("free_rx_words", rx_cnt[2], QW);
    core_running = '0;

    // enable dropped mid-stream finishes the current query only
    clear_logs();
    queue_query();
    queue_query();
    n = 0;
    while (rx_cnt[3] < 50 && n < 500) begin
      tick();
      n++;
    end
    if (rx_cnt[3] < 50) fail_msg("timeout_en_mid");
    enable = 1'b0;
    n = 0;
    while (src_q.size() > QW && n < 1500) begin
      tick();
      n++;
    end
    repeat (30) tick();
    chk("en_first_done", rx_cnt[3], QW);
    chk("en_blocked_start", start_log.size(), 1);
    chk("en_blocked_read", src_q.size(), QW);
    enable = 1'b1;
    wait_src(1500, "timeout_en_resume");
    chk("en_second_core", first_start(1), 0);
    chk("en_second_rx", rx_cnt[0], QW);

    // result collection pairs, first one concurrent with a dispatch
    for (int c = 0; c < 5; c++) begin
      clear_logs();
      if (c == 0) queue_query();
      load_res(cv[c].first);
      load_res(cv[c].second);
      wait_sink(300, "timeout_cvec");
      chk("cvec_acc_cnt", acc_cnt, 6);
      if (c == 0) begin
        wait_src(1500, "timeout_concurrent");
        chk("concurrent_rx", rx_cnt[1], QW);
      end
    end

    // sink full for 10 cycles while word 2 is pending
    clear_logs();
    load_res(2);
    n = 0;
    while (acc_cnt < 1 && n < 50) begin
      tick();
      n++;
    end
    if (acc_cnt < 1) fail_msg("timeout_full_w1");
    sink_full_m = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("full_core_view", core_sink_full[2], 1'b1);
      chk("full_wren_held", sink_fifo_wren, 1'b1);
    end
    chk("full_no_advance", acc_cnt, 1);
    sink_full_m = 1'b0;
    wait_sink(100, "timeout_full_rest");
    chk("full_total_words", acc_cnt, 3);

    // reset at word 100 of a stream
    clear_logs();
    queue_query();
    n = 0;
    while (rx_total() < 100 && n < 800) begin
      tick();
      n++;
    end
    if (rx_total() < 100) fail_msg("timeout_rst_mid");
    rst = 1'b1;
    #1 check_reset_outs("rst_mid");
    src_q.delete();
    src_exp.delete();
    pend_src = 1'b0;
    pend_core = '0;
    tick();
    tick();
    rst = 1'b0;

    // three queries and three results after reset
    clear_logs();
    repeat (3) queue_query();
    load_res(0);
    load_res(1);
    load_res(2);
    wait_src(4000, "timeout_post_rst");
    wait_sink(300, "timeout_post_rst_sink");
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_core", first_start(i), i);
      chk("post_rst_rx", rx_cnt[i], QW);
    end
    chk("post_rst_acc", acc_cnt, 9);
`ifdef DTW_DISPATCH_STATS_EN
    chk("stat_dispatched", stat_dispatched, 32'd3);
    chk("stat_returned", stat_returned, 32'd3);
`endif
    chk("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dtw_dispatch_arbiter.md
DTW_DISPATCH_ARBITER -- requirements
Module: dtw_dispatch_arbiter

Interface
REQ-001 Parameter N_CORES, default 4: number of DTW cores served, 2..8.
REQ-002 Parameter SQG_SIZE, default 250: query samples following each query ID word.
REQ-003 Parameter axi_dwidth, default 32: word width of all FIFO data ports.
REQ-004 clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  level; 1 permits new dispatches.
REQ-007 busy  out  1  1 while any query is being streamed or any core is running.
REQ-008 src_fifo_rden / src_fifo_empty / src_fifo_data  out 1 / in 1 / in axi_dwidth  upstream query FIFO (first-word-fall-through).
REQ-009 core_start  out  N_CORES  one-cycle start pulse per core.
REQ-010 core_running  in  N_CORES  per-core running flag.
REQ-011 core_src_empty  out  N_CORES  per-core view of source empty.
REQ-012 core_src_rden  in  N_CORES  per-core source read enable.
REQ-013 core_src_data  out  axi_dwidth  source data broadcast to all cores.
REQ-014 core_sink_wren  in  N_CORES  per-core result write enable.
REQ-015 core_sink_data  in  N_CORES*axi_dwidth  packed per-core result words; core i at bits [i*axi_dwidth +: axi_dwidth].
REQ-016 core_sink_full  out  N_CORES  per-core view of sink full.
REQ-017 sink_fifo_wren / sink_fifo_full / sink_fifo_data  out 1 / in 1 / out axi_dwidth  downstream result FIFO.

Function
REQ-018 Dispatch FSM SHALL have states D_IDLE, D_SELECT, D_START, D_STREAM.
REQ-019 D_IDLE -> D_SELECT when enable=1 and src_fifo_empty=0.
REQ-020 D_SELECT SHALL grant the first core with core_running=0, searching round-robin from dispatch pointer dp; it SHALL stay in D_SELECT while no core is idle.
REQ-021 D_START SHALL assert core_start[sel] for exactly one cycle, then enter D_STREAM.
REQ-022 In D_STREAM: core_src_empty[sel]=src_fifo_empty; src_fifo_rden=core_src_rden[sel]; all other core_src_empty bits=1; other cores' rden ignored.
REQ-023 Outside D_STREAM: all core_src_empty=1 and src_fifo_rden=0.
REQ-024 A word is transferred in each cycle where src_fifo_rden=1 and src_fifo_empty=0; a counter SHALL count transferred words.
REQ-025 After SQG_SIZE+1 transferred words (ID plus samples), dp SHALL become sel+1 mod N_CORES; FSM SHALL return to D_IDLE; no further words SHALL pass to sel.
REQ-026 core_src_data SHALL equal src_fifo_data combinationally.
REQ-027 Result collector SHALL grant one core at a time, round-robin from result pointer rp, choosing a core asserting core_sink_wren.
REQ-028 A grant SHALL lock for exactly 3 accepted words (qid, position, minval).
REQ-029 For the granted core: core_sink_full[g]=sink_fifo_full, sink_fifo_wren=core_sink_wren[g]; an accepted word has wren=1 and full=0.
REQ-030 All non-granted cores SHALL see core_sink_full=1.
REQ-031 After the third accepted word the grant SHALL release and rp SHALL become g+1 mod N_CORES.
REQ-032 sink_fifo_data SHALL be the granted core's word, zero when nothing is granted.
REQ-033 Dispatch and collection SHALL operate concurrently and independently.
REQ-034 Dropping enable mid-stream SHALL NOT abort the current query; it blocks only the next D_IDLE exit.
REQ-035 If sink_fifo_full stays 1, the grant SHALL hold and the word count SHALL NOT advance.

Reset
REQ-036 While rst=1: FSM=D_IDLE; dp=0; rp=0; no grant; word counters=0; core_start=0; src_fifo_rden=0; sink_fifo_wren=0; sink_fifo_data=0; busy=0; core_src_empty all 1; core_sink_full all 1.
REQ-037 Reset asserted mid-stream or mid-result SHALL abandon the transfer; partial data is not replayed.

Configuration
REQ-038 Macro DTW_DISPATCH_STATS_EN defined: extra outputs stat_dispatched[31:0] and stat_returned[31:0], reset 0, wrapping. stat_dispatched +1 per D_START; stat_returned +1 per completed 3-word result.
REQ-039 Macro undefined: these ports and counters SHALL NOT exist; all other behaviour identical.

Verification
REQ-040 N_CORES=4, all idle, 3 queries queued -> core_start pulses on cores 0, 1, 2 in order, each receiving exactly 251 words.
REQ-041 All 4 cores running, 5th query queued -> FSM holds D_SELECT, src_fifo_rden=0; core 2 drops running -> core 2 started next.
REQ-042 Cores 1 and 3 assert core_sink_wren in the same cycle, rp=0 -> core 1 writes 3 words, then core 3 writes 3 words; no interleaving.
REQ-043 sink_fifo_full=1 for 10 cycles during word 2 -> grant held, no word lost or duplicated, order qid/position/minval preserved.
REQ-044 rst pulsed at word 100 of a stream -> all outputs at reset values asynchronously; next query goes to core 0.
REQ-045 DTW_DISPATCH_STATS_EN defined, 3 queries run to completion -> stat_dispatched=3, stat_returned=3.
